serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that time-shares a single full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requester issuing start/operand handshakes and the combinational full-adder datapath. It sequences the operand shift, carry feedback and result assembly, and reports completion with a one-cycle done pulse.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 1

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held between operations
- cout  output  1  registered carry-out; held between operations

## Operation
- States:
  - IDLE: accepts start.
  - RUN: issues one bit per cycle.
  - DONE: single cycle.
- IDLE → RUN on start=1. On that edge:
  - a_sh←a, b_sh←b.
  - carry←cin.
  - bit counter←0.
  - acc←0.
- RUN, each cycle, drive the full-adder cell with x=a_sh[0], y=b_sh[0], z=carry. On the edge:
  - acc←{full_sum, acc[WIDTH-1:1]}.
  - carry←full_carry.
  - a_sh, b_sh shift right one bit.
  - counter+1.
- RUN → DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1). That same edge loads:
  - sum←{full_sum, acc[WIDTH-1:1]}.
  - cout←full_carry.
- DONE → IDLE unconditionally on the next edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- sum/cout change only on the RUN → DONE edge and on reset. They are stable throughout RUN.
- start while busy (RUN or DONE) is ignored. It is not queued, and operands are not re-sampled.
- a/b/cin changing after acceptance have no effect on the operation in flight.
- Reset asserted at any time, including mid-RUN:
  - state→IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - carry, counter, acc, a_sh, b_sh all cleared.
  - The partial operation is discarded.
  - The first start after reset deasserts is accepted normally.
- Counter width: $clog2(WIDTH+1). It never wraps within an operation.

## Timing
- Start accepted at edge k. Then:
  - busy=1 after edge k.
  - Bits 0..WIDTH-1 processed across edges k+1..k+WIDTH.
  - done=1 and result valid after edge k+WIDTH, for exactly one cycle.
  - busy=0 after edge k+WIDTH+1.
- Latency start-edge → done: WIDTH cycles. Throughput: one operation per WIDTH+2 cycles. The next start can be accepted at edge k+WIDTH+2.
- WIDTH=1: RUN lasts one cycle; done follows edge k+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - state typedef/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH default constant.
- One sub-module: full_adder_cell. Ports x, y, z, full_carry, full_sum. Purely combinational, instantiated exactly once.
- Controller body: state register, counter, shift registers, carry flop, result registers.

## Test plan
- WIDTH=8: a=8'h5A, b=8'h33, cin=0, start at edge k → done pulse after edge k+8 only; sum=8'h8D, cout=0; busy low after edge k+9.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1. Prior result must hold unchanged during the second RUN.
- WIDTH=8: start pulsed at k+3 and during DONE, with different operands → ignored. Single done pulse with the first result. Next start accepted at k+10, and its result is correct.
- Reset asserted asynchronously mid-RUN (between edges k+4 and k+5) → busy, done, sum, cout go 0 immediately with no done pulse. A fresh 8'h01+8'h01 after release → sum=8'h02.
- WIDTH=1, all 8 {a,b,cin} combinations → {cout,sum} matches the full-adder truth table. done follows each accepting edge by exactly 1 cycle.
- Random regression, WIDTH=8 and WIDTH=13: 1000 operations with back-to-back starts → every result equals a+b+cin. Done spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg : shared state encoding and defaults for the
//                         bit-serial adder controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder_cell : single-bit combinational full adder shared by every bit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic full_carry,
  output logic full_sum
);

  assign full_sum   = x ^ y ^ z;
  assign full_carry = (x & y) | (z & (x ^ y));

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl : adds two WIDTH-bit operands LSB-first through one
//                     full-adder cell, one bit per clock, with a done pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;

  logic             full_sum;
  logic             full_carry;
  logic [WIDTH:0]   acc_wide;
  logic [WIDTH-1:0] acc_next;
  logic             unused_acc_lsb;

  full_adder_cell u_fa (
    .x          (a_sh[0]),
    .y          (b_sh[0]),
    .z          (carry),
    .full_carry (full_carry),
    .full_sum   (full_sum)
  );

  // New bit enters at the MSB; the oldest accumulator bit falls off the bottom.
  assign acc_wide       = {full_sum, acc};
  assign acc_next       = acc_wide[WIDTH:1];
  assign unused_acc_lsb = acc_wide[0];

  // Both status outputs decode straight from the state flops.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            bit_cnt <= '0;
            acc     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry   <= full_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            sum   <= acc_next;
            cout  <= full_carry;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl : self-checking bench for WIDTH = 8, 13 and 1 instances
//                        sharing one stimulus bus, checked against a + b + cin.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] a = '0;
  logic [12:0] b = '0;
  logic        cin = 1'b0;

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;
  logic        busy1, done1, cout1;
  logic [0:0]  sum1;

  int total = 0;
  int bad   = 0;
  int cur_w = 8;

  logic        sel_busy, sel_done, sel_cout;
  logic [12:0] sel_sum;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always_comb begin
    sel_busy = busy8;
    sel_done = done8;
    sel_cout = cout8;
    sel_sum  = {5'b0, sum8};
    case (cur_w)
      13: begin
        sel_busy = busy13; sel_done = done13; sel_cout = cout13; sel_sum = sum13;
      end
      1: begin
        sel_busy = busy1; sel_done = done1; sel_cout = cout1; sel_sum = {12'b0, sum1};
      end
      default: ;
    endcase
  end

  // Reference: plain integer addition truncated to w+1 bits.
  function automatic logic [13:0] ref_add(input int w, input logic [12:0] x,
                                          input logic [12:0] y, input logic c);
    logic [13:0] m;
    logic [13:0] t;
    m = (14'd1 << w) - 14'd1;
    t = (14'(x) & m) + (14'(y) & m) + 14'(c);
    return t & ((14'd1 << (w + 1)) - 14'd1);
  endfunction

  task automatic idle_wait();
    start = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  // Issues one start and observes the selected instance for w+2 cycles.
  task automatic run_op(input int w, input logic [12:0] oa, input logic [12:0] ob,
                        input logic oc, input int p1, input int p2,
                        output int done_cycle, output int done_count,
                        output logic [12:0] rs, output logic rc,
                        output logic busy_ok, output logic held);
    logic [12:0] s0;
    logic        c0;
    cur_w = w;
    #0;
    s0 = sel_sum; c0 = sel_cout;
    done_cycle = -1; done_count = 0; busy_ok = 1'b1; held = 1'b1; rs = '0; rc = 1'b0;
    a = oa; b = ob; cin = oc; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= w + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (sel_busy !== (i <= w)) busy_ok = 1'b0;
      if (sel_done === 1'b1) begin
        done_count++; done_cycle = i; rs = sel_sum; rc = sel_cout;
      end
      if (i < w && (sel_sum !== s0 || sel_cout !== c0)) held = 1'b0;
      start = (i == p1 || i == p2);
      a = 13'($urandom); b = 13'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {busy8, done8, cout8, busy13, done13, cout13, busy1, done1, cout1, 7'b0};
    total++;
    if (obs !== 16'h0) begin
      bad++; $display("FAIL reset_flags got=%h want=0000", obs);
    end
    total++;
    if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum8 got=%h want=00", sum8); end
    total++;
    if (sum13 !== 13'h0) begin bad++; $display("FAIL reset_sum13 got=%h want=0", sum13); end
    total++;
    if (sum1 !== 1'b0) begin bad++; $display("FAIL reset_sum1 got=%b want=0", sum1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, dn; logic [12:0] rs; logic rc, bok, hld;
    idle_wait();
    run_op(8, 13'h5A, 13'h33, 1'b0, -1, -1, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'h8D || rc !== 1'b0) begin
      bad++; $display("FAIL basic_result got=%b_%h want=0_8d", rc, rs[7:0]);
    end
    total++;
    if (dc !== 8 || dn !== 1) begin
      bad++; $display("FAIL basic_done_timing got cycle=%0d count=%0d want cycle=8 count=1", dc, dn);
    end
    total++;
    if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bok); end
  endtask

  task automatic test_carry_hold();
    int dc, dn; logic [12:0] rs; logic rc, bok, hld;
    idle_wait();
    run_op(8, 13'hFF, 13'h01, 1'b0, -1, -1, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'h00 || rc !== 1'b1) begin
      bad++; $display("FAIL carry_ff01 got=%b_%h want=1_00", rc, rs[7:0]);
    end
    run_op(8, 13'hFF, 13'hFF, 1'b1, -1, -1, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'hFF || rc !== 1'b1) begin
      bad++; $display("FAIL carry_ffff1 got=%b_%h want=1_ff", rc, rs[7:0]);
    end
    total++;
    if (hld !== 1'b1) begin bad++; $display("FAIL result_hold got=%b want=1", hld); end
    total++;
    if (dc !== 8 || dn !== 1 || bok !== 1'b1) begin
      bad++; $display("FAIL carry_timing got cycle=%0d count=%0d busy=%b want 8/1/1", dc, dn, bok);
    end
  endtask

  task automatic test_ignore_start();
    int dc, dn; logic [12:0] rs; logic rc, bok, hld;
    idle_wait();
    run_op(8, 13'h12, 13'h34, 1'b1, 2, 8, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'h47 || rc !== 1'b0) begin
      bad++; $display("FAIL ignore_result got=%b_%h want=0_47", rc, rs[7:0]);
    end
    total++;
    if (dc !== 8 || dn !== 1 || bok !== 1'b1) begin
      bad++; $display("FAIL ignore_timing got cycle=%0d count=%0d busy=%b want 8/1/1", dc, dn, bok);
    end
    run_op(8, 13'hC8, 13'h64, 1'b0, -1, -1, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'h2C || rc !== 1'b1 || dc !== 8 || dn !== 1) begin
      bad++; $display("FAIL ignore_next got=%b_%h cycle=%0d count=%0d want=1_2c cycle=8 count=1",
                      rc, rs[7:0], dc, dn);
    end
  endtask

  task automatic test_async_reset();
    int dc, dn, seen; logic [12:0] rs; logic rc, bok, hld;
    idle_wait();
    cur_w = 8;
    a = 13'hC3; b = 13'h5A; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      bad++; $display("FAIL async_reset got busy=%b done=%b cout=%b sum=%h want all 0",
                      busy8, done8, cout8, sum8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL async_no_done got=%0d want=0", seen); end
    run_op(8, 13'h01, 13'h01, 1'b0, -1, -1, dc, dn, rs, rc, bok, hld);
    total++;
    if (rs[7:0] !== 8'h02 || rc !== 1'b0 || dc !== 8 || dn !== 1) begin
      bad++; $display("FAIL async_fresh got=%b_%h cycle=%0d want=0_02 cycle=8", rc, rs[7:0], dc);
    end
  endtask

  task automatic test_width1();
    int dc, dn; logic [12:0] rs; logic rc, bok, hld;
    logic [2:0] v; logic [13:0] exp;
    idle_wait();
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      exp = ref_add(1, {12'b0, v[2]}, {12'b0, v[1]}, v[0]);
      run_op(1, {12'b0, v[2]}, {12'b0, v[1]}, v[0], -1, -1, dc, dn, rs, rc, bok, hld);
      total++;
      if ({rc, rs[0]} !== exp[1:0] || dc !== 1 || dn !== 1 || bok !== 1'b1) begin
        bad++; $display("FAIL width1 abc=%b got=%b%b cycle=%0d count=%0d want=%b cycle=1 count=1",
                        v, rc, rs[0], dc, dn, exp[1:0]);
      end
    end
  endtask

  task automatic test_back_to_back(input int w, input int n);
    int dc, dn; logic [12:0] rs, oa, ob; logic rc, bok, hld, oc;
    logic [13:0] exp, m;
    m = (14'd1 << w) - 14'd1;
    idle_wait();
    for (int k = 0; k < n; k++) begin
      oa = 13'($urandom); ob = 13'($urandom); oc = 1'($urandom);
      exp = ref_add(w, oa, ob, oc);
      run_op(w, oa, ob, oc, -1, -1, dc, dn, rs, rc, bok, hld);
      total++;
      if ((14'(rs) & m) !== (exp & m) || rc !== exp[w]) begin
        bad++; $display("FAIL b2b_w%0d_result op=%0d got=%b_%h want=%b_%h",
                        w, k, rc, rs, exp[w], exp & m);
      end
      total++;
      if (dc !== w || dn !== 1 || bok !== 1'b1) begin
        bad++; $display("FAIL b2b_w%0d_timing op=%0d got cycle=%0d count=%0d busy=%b want %0d/1/1",
                        w, k, dc, dn, bok, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_hold();
    test_ignore_start();
    test_async_reset();
    test_width1();
    test_back_to_back(8, 1000);
    test_back_to_back(13, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
